// File: rtl/detector_secuencia_pkg.sv
// rtl/detector_secuencia_pkg.sv - shared state type and pattern constant for the 1101 detector
package detector_secuencia_pkg;

    // Each state names the longest prefix of 1101 matched by the most recent sampled bits
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_11   = 3'd2,
        S_110  = 3'd3,
        S_DET  = 3'd4
    } state_t;

    // Pattern searched for, oldest bit in the MSB
    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/detector_secuencia_bit_tick_gen.sv
// rtl/detector_secuencia_bit_tick_gen.sv - one-clock sample tick every CLKS_PER_BIT clocks
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the edge where the counter sits at its last value, then wrap
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Divider counter register; restarts the bit period on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/detector_secuencia.sv
// rtl/detector_secuencia.sv - Moore FSM detecting overlapping 1101 on a bit-rate sampled serial input
module detector_secuencia
    import detector_secuencia_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic dato,
    output logic detectada
);

    logic   tick;
    state_t state_q;
    state_t state_d;
    logic   detectada_q;
    logic   detectada_d;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Next state advances only on sample ticks; the flag follows the state it will hold
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE:  state_d = dato ? S_1   : S_IDLE;
                S_1:     state_d = dato ? S_11  : S_IDLE;
                S_11:    state_d = dato ? S_11  : S_110;
                S_110:   state_d = dato ? S_DET : S_IDLE;
                S_DET:   state_d = dato ? S_11  : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (state_q > S_DET) begin
            state_d = S_IDLE;
        end
        detectada_d = (state_d == S_DET);
    end

    // State and registered detection flag; reset discards any partial match
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            detectada_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            detectada_q <= detectada_d;
        end
    end

    assign detectada = detectada_q;

endmodule

// File: tb/tb_detector_secuencia.sv
// tb/tb_detector_secuencia.sv - randomized and directed checks of detector_secuencia against a bit-history model
module tb_detector_secuencia;
    import detector_secuencia_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic dato = 1'b0;
    logic det_b2;
    logic det_b1;

    int checks = 0;
    int failures = 0;

    // Model per instance: index 0 is CLKS_PER_BIT=2, index 1 is CLKS_PER_BIT=1
    int       cpb [2] = '{2, 1};
    int       edges [2];
    int       nbits [2];
    logic [3:0] hist [2];
    logic     exp_det [2];
    logic     prev_det [2];
    int       rises [2];
    int       highs [2];

    always #5 clk = ~clk;

    detector_secuencia #(.CLKS_PER_BIT(2)) dut_b2 (
        .clk      (clk),
        .reset    (reset),
        .dato     (dato),
        .detectada(det_b2)
    );

    detector_secuencia #(.CLKS_PER_BIT(1)) dut_b1 (
        .clk      (clk),
        .reset    (reset),
        .dato     (dato),
        .detectada(det_b1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_pulse_counts();
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0;
            highs[i] = 0;
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, compare just after it
    task automatic cycle(input logic r, input logic d);
        logic got [2];
        reset = r;
        dato  = d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                edges[i]   = 0;
                nbits[i]   = 0;
                hist[i]    = 4'b0000;
                exp_det[i] = 1'b0;
            end else begin
                edges[i]++;
                if (edges[i] % cpb[i] == 0) begin
                    hist[i]    = {hist[i][2:0], d};
                    nbits[i]++;
                    exp_det[i] = (nbits[i] >= 4) && (hist[i] == PATTERN);
                end
            end
        end
        #1;
        got[0] = det_b2;
        got[1] = det_b1;
        check_val("det_cpb2", 32'(det_b2), 32'(exp_det[0]));
        check_val("det_cpb1", 32'(det_b1), 32'(exp_det[1]));
        check_val("tick_cpb2", 32'(dut_b2.u_tick.tick), 32'(((edges[0] + 1) % cpb[0]) == 0));
        check_val("tick_cpb1", 32'(dut_b1.u_tick.tick), 32'(((edges[1] + 1) % cpb[1]) == 0));
        if (!r) begin
            check_val("rst_state_cpb2", 32'(dut_b2.state_q), 32'(S_IDLE));
            check_val("rst_state_cpb1", 32'(dut_b1.state_q), 32'(S_IDLE));
        end
        for (int i = 0; i < 2; i++) begin
            if (got[i] && !prev_det[i]) rises[i]++;
            if (got[i]) highs[i]++;
            prev_det[i] = got[i];
        end
    endtask

    // Send a bit string (MSB first) holding each bit for 'hold' clocks
    task automatic send_bits(input logic [15:0] bits, input int n, input int hold);
        for (int b = n - 1; b >= 0; b--) begin
            for (int h = 0; h < hold; h++) cycle(1'b1, bits[b]);
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, k[0]);
        for (int i = 0; i < 2; i++) prev_det[i] = 1'b0;
        clear_pulse_counts();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) prev_det[i] = 1'b0;

        // Reset held three clocks with dato toggling
        do_reset(3);

        // Basic match at 2 clocks per bit, two trailing zero bits to close the pulse
        send_bits(16'b110100, 6, 2);
        check_val("basic_rises", 32'(rises[0]), 32'd1);
        check_val("basic_highs", 32'(highs[0]), 32'd2);

        // Overlap 1101101
        do_reset(1);
        send_bits(16'b110110100, 9, 2);
        check_val("overlap_rises", 32'(rises[0]), 32'd2);
        check_val("overlap_highs", 32'(highs[0]), 32'd4);

        // Long stream, three detections
        do_reset(1);
        send_bits(16'b110110101110100, 15, 2);
        check_val("long_rises", 32'(rises[0]), 32'd3);

        // Near misses
        do_reset(1);
        send_bits(16'b10100111001, 11, 2);
        check_val("near_rises", 32'(rises[0]), 32'd0);

        // Mid-sequence reset discards the partial 110
        do_reset(1);
        send_bits(16'b110, 3, 2);
        cycle(1'b0, 1'b1);
        send_bits(16'b100, 3, 2);
        check_val("midrst_rises", 32'(rises[0]), 32'd0);
        send_bits(16'b110100, 6, 2);
        check_val("midrst_after_rises", 32'(rises[0]), 32'd1);

        // Basic match at one clock per bit
        do_reset(1);
        send_bits(16'b110100, 6, 1);
        check_val("cpb1_rises", 32'(rises[1]), 32'd1);
        check_val("cpb1_highs", 32'(highs[1]), 32'd1);

        // Random stream with occasional resets
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
